// File: rtl/grid_sequencer.sv
// grid_sequencer: replays one latched input sample against a table of grid/scale points as
// three lock-step AXI-Stream beats. Optional sweep counter enabled by GRID_SEQUENCER_CNT_EN.
module grid_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int SCALE_WIDTH = 16,
  parameter int GRID_POINTS = 8,
  parameter int ADDR_WIDTH  = $clog2(GRID_POINTS)
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]  cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0]  cfg_grid,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [ADDR_WIDTH:0]    cfg_num_points,

  output logic                   busy,
`ifdef GRID_SEQUENCER_CNT_EN
  output logic [15:0]            sweep_count,
`endif

  input  logic [DATA_WIDTH-1:0]  s_axis_data_tdata,
  input  logic                   s_axis_data_tvalid,
  output logic                   s_axis_data_tready,

  output logic [DATA_WIDTH-1:0]  m_axis_data_tdata,
  output logic                   m_axis_data_tvalid,
  input  logic                   m_axis_data_tready,
  output logic                   m_axis_data_tlast,

  output logic [DATA_WIDTH-1:0]  m_axis_grid_tdata,
  output logic                   m_axis_grid_tvalid,
  input  logic                   m_axis_grid_tready,
  output logic                   m_axis_grid_tlast,

  output logic [SCALE_WIDTH-1:0] m_axis_scle_tdata,
  output logic                   m_axis_scle_tvalid,
  input  logic                   m_axis_scle_tready,
  output logic                   m_axis_scle_tlast
);

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LP_NPTS = (ADDR_WIDTH+1)'(GRID_POINTS);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(GRID_POINTS - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE  = ADDR_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [DATA_WIDTH-1:0]  r_grid  [GRID_POINTS];
  logic [SCALE_WIDTH-1:0] r_scale [GRID_POINTS];
  logic [DATA_WIDTH-1:0]  r_sample;
  logic [ADDR_WIDTH-1:0]  r_k;
  logic [ADDR_WIDTH-1:0]  r_last_k;
  logic [2:0]             r_acc;

  logic                   w_in_hs;
  logic                   w_cfg_wr;
  logic                   w_sweep;
  logic                   w_last_beat;
  logic                   w_beat_done;
  logic [ADDR_WIDTH-1:0]  w_last_k_nxt;
  logic [2:0]             w_valid;
  logic [2:0]             w_ready;
  logic [2:0]             w_hs;

  assign w_sweep     = (r_state == ST_SWEEP);
  assign w_in_hs     = (r_state == ST_IDLE) && s_axis_data_tvalid;
  assign w_cfg_wr    = (r_state == ST_IDLE) && cfg_wr_en && ({1'b0, cfg_wr_addr} < LP_NPTS);
  assign w_last_beat = (r_k == r_last_k);

  // Channel order in the 3-bit vectors: {scle, grid, data}.
  // Valid is derived purely from state and accepted flags, never from tready.
  assign w_valid     = {3{w_sweep}} & ~r_acc;
  assign w_ready     = {m_axis_scle_tready, m_axis_grid_tready, m_axis_data_tready};
  assign w_hs        = w_valid & w_ready;
  assign w_beat_done = w_sweep && ((r_acc | w_hs) == 3'b111);

  // Clamp the requested point count to [1, GRID_POINTS], stored as the last index.
  always_comb begin
    w_last_k_nxt = '0;
    if (cfg_num_points == '0) begin
      w_last_k_nxt = '0;
    end else if (cfg_num_points >= LP_NPTS) begin
      w_last_k_nxt = LP_LAST;
    end else begin
      w_last_k_nxt = cfg_num_points[ADDR_WIDTH-1:0] - LP_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_in_hs) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_beat_done && w_last_beat) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_data_tready = 1'b0;
    busy               = 1'b0;
    case (r_state)
      ST_IDLE:  s_axis_data_tready = 1'b1;
      ST_SWEEP: busy               = 1'b1;
      default: begin
        s_axis_data_tready = 1'b0;
        busy               = 1'b0;
      end
    endcase
  end

  // Register file: written only in IDLE, so a same-cycle write lands before the first beat reads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < GRID_POINTS; i++) begin
        r_grid[i]  <= '0;
        r_scale[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      r_grid[cfg_wr_addr]  <= cfg_grid;
      r_scale[cfg_wr_addr] <= cfg_scale;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
      r_k      <= '0;
      r_last_k <= '0;
      r_acc    <= '0;
    end else if (w_in_hs) begin
      r_sample <= s_axis_data_tdata;
      r_last_k <= w_last_k_nxt;
      r_k      <= '0;
      r_acc    <= '0;
    end else if (w_sweep) begin
      if (w_beat_done) begin
        r_acc <= '0;
        r_k   <= w_last_beat ? '0 : r_k + LP_ONE;
      end else begin
        r_acc <= r_acc | w_hs;
      end
    end
  end

  always_comb begin
    m_axis_data_tvalid = w_valid[0];
    m_axis_grid_tvalid = w_valid[1];
    m_axis_scle_tvalid = w_valid[2];
    m_axis_data_tdata  = '0;
    m_axis_grid_tdata  = '0;
    m_axis_scle_tdata  = '0;
    m_axis_data_tlast  = 1'b0;
    m_axis_grid_tlast  = 1'b0;
    m_axis_scle_tlast  = 1'b0;
    if (w_sweep) begin
      m_axis_data_tdata = r_sample;
      m_axis_grid_tdata = r_grid[r_k];
      m_axis_scle_tdata = r_scale[r_k];
      m_axis_data_tlast = w_last_beat;
      m_axis_grid_tlast = w_last_beat;
      m_axis_scle_tlast = w_last_beat;
    end
  end

`ifdef GRID_SEQUENCER_CNT_EN
  logic [15:0] r_sweep_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sweep_count <= '0;
    end else if (w_beat_done && w_last_beat && (r_sweep_count != '1)) begin
      r_sweep_count <= r_sweep_count + 16'd1;
    end
  end

  assign sweep_count = r_sweep_count;
`else
  // No sweep counter in this build.
`endif

endmodule
